addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It is the next generation of the 32-bit combinational add32 used in the processor datapath. The carry chain is split into STAGES registered slices, and it adds add/sub mode, carry-out, signed overflow and zero flags, plus a valid/ready handshake with backpressure. It serves as the ALU/address-add core for the pipelined datapath and the multi-cycle multiply/divide unit.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, number of pipeline register stages; 1..WIDTH; latency equals STAGES.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat present
in_ready  out  1  block accepts a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
sub  in  1  0: a+b; 1: a-b
out_valid  out  1  result beat present
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry-out; for sub, 1 = no borrow
ovf  out  1  signed overflow
zero  out  1  sum == 0

Behaviour:
- Reset, asynchronous and active-high. While asserted, every stage valid bit = 0, out_valid = 0, and sum, cout, ovf and zero = 0. in_ready = 1 the cycle after deassertion. A reset mid-operation drops all in-flight beats; no partial result is emitted.
- Slice width is S = WIDTH/STAGES. If WIDTH % STAGES != 0, elaboration fails via a generate-time error.
- Sub mode: the effective B is ~b and the carry-in is 1. The sub flag travels with the beat.
- Stage k (0..STAGES-1) adds slice k of A and effective B with the carry registered from stage k-1 (stage 0 uses the carry-in).
  - Completed low slices and not-yet-used high operand slices are registered alongside.
  - No combinational carry path crosses a stage register.
- Global advance enable: en = !out_valid | out_ready. in_ready = en (combinational from out_valid/out_ready only; no combinational path from in_valid).
- A beat is accepted when in_valid & in_ready. On en, every stage shifts by one; each stage valid bit follows the beat.
- On !en, all stages hold, and the outputs are stable and unchanged until accepted.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES-1. Throughput is 1 beat per cycle with out_ready held high. Bubbles propagate as valid = 0.
- Flags are computed in the final stage from the full result:
  - cout = carry out of bit WIDTH-1.
  - ovf = (A[msb] == Beff[msb]) & (sum[msb] != A[msb]).
  - zero = ~|sum.
- Outputs are registered. When out_valid = 0, sum and flags hold their last value (don't-care for the consumer).
- Simultaneous final-stage output accept and new input accept in the same cycle is legal and lossless.
- STAGES = 1 degenerates to a single registered adder with the same handshake.

Optional Feature:
ADDSUB_PIPE_SAT_EN
- Defined: adds an input port sat (1 bit, carried with the beat). When sat = 1 and ovf = 1, sum is clamped to 0x7FF..F if A[msb] = 0, else 0x800..0. ovf still reports 1, zero is computed on the clamped value, and cout is unchanged.
- Undefined: the port is absent and results wrap modulo 2^WIDTH.

Decomposition:
- Shared package addsub_pkg holds:
  - flag bit-index constants (FLAG_COUT = 0, FLAG_OVF = 1, FLAG_ZERO = 2);
  - localparam function slice_w(WIDTH, STAGES);
  - the flags struct typedef used by the ALU.
- One sub-module: addsub_slice. It is a combinational S-bit adder slice (a, b, cin -> s, cout, plus the msb carry-in for overflow), instantiated STAGES times inside a generate loop, with registers in the parent.

Test Plan:
- WIDTH=32, STAGES=4, sub=0, a=1, b=3 -> out_valid after 4 edges; sum=4, cout=0, ovf=0, zero=0. Then a=15, b=31 -> sum=46.
- a=0xFFFFFFFF, b=1, sub=0 -> sum=0, cout=1, ovf=0, zero=1. Also a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1, cout=0.
- sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. Also sub=1, a=7, b=7 -> sum=0, cout=1, zero=1.
- Back-to-back 16 random beats with out_ready toggling 1-0-0-1…:
  - results match a scoreboard in order;
  - no drop or duplicate;
  - sum and flags stable while out_valid & !out_ready;
  - in_ready = 0 exactly when stalled.
- Assert reset for 1 cycle with 3 beats in flight -> out_valid=0 immediately (asynchronously). The next accepted beat (a=2, b=2) yields sum=4 after exactly 4 edges.
- With ADDSUB_PIPE_SAT_EN, sat=1, a=0x7FFFFFFF, b=1 -> sum=0x7FFFFFFF, ovf=1. Also sat=1, a=0x80000000, b=1, sub=1 -> sum=0x80000000, ovf=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: flag bit positions,
// the flags struct and the slice-width helper.
package addsub_pkg;

    localparam int FLAG_COUT = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_ZERO = 2;

    // Member order makes the packed bit index match the FLAG_* constants.
    typedef struct packed {
        logic zero;
        logic ovf;
        logic cout;
    } addsub_flags_t;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit adder slice; also exposes the carry into its msb so the
// last slice can derive signed overflow.
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign cmsb      = s[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/sub, one carry slice per register stage, with
// valid/ready backpressure. ADDSUB_PIPE_SAT_EN adds the sat input (clamp on overflow).
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef ADDSUB_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int S = slice_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("addsub_pipe: STAGES must be 1..WIDTH and divide WIDTH");
    end

    logic             en;
    logic             vld_q;
    logic [WIDTH-1:0] sum_q;
    addsub_flags_t    flags_q;

    // Stage k operands: index 0 comes from the ports, index k>0 from register k-1.
    logic             x_vld [STAGES];
    logic             x_sat [STAGES];
    logic             x_c   [STAGES];
    logic [WIDTH-1:0] x_a   [STAGES];
    logic [WIDTH-1:0] x_b   [STAGES];
    logic [WIDTH-1:0] x_s   [STAGES];

    assign en        = !vld_q || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q;
    assign sum       = sum_q;
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;

    assign x_vld[0] = in_valid;
    assign x_a[0]   = a;
    assign x_b[0]   = sub ? ~b : b;
    assign x_c[0]   = sub;
    assign x_s[0]   = '0;
`ifdef ADDSUB_PIPE_SAT_EN
    assign x_sat[0] = sat;
`else
    assign x_sat[0] = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [S-1:0]     s_k;
        logic             c_k;
        logic             cmsb_k;
        logic [WIDTH-1:0] nsum;

        addsub_slice #(.W(S)) u_slice (
            .a    (x_a[k][k*S +: S]),
            .b    (x_b[k][k*S +: S]),
            .cin  (x_c[k]),
            .s    (s_k),
            .cout (c_k),
            .cmsb (cmsb_k)
        );

        always_comb begin
            nsum          = x_s[k];
            nsum[k*S +: S] = s_k;
        end

        if (k < STAGES - 1) begin : g_mid
            logic             vld_r;
            logic             sat_r;
            logic             c_r;
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;
            logic [WIDTH-1:0] s_r;
            logic             unused_cmsb;

            assign unused_cmsb = cmsb_k;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_r <= 1'b0;
                    sat_r <= 1'b0;
                    c_r   <= 1'b0;
                    a_r   <= '0;
                    b_r   <= '0;
                    s_r   <= '0;
                end else if (en) begin
                    vld_r <= x_vld[k];
                    sat_r <= x_sat[k];
                    c_r   <= c_k;
                    a_r   <= x_a[k];
                    b_r   <= x_b[k];
                    s_r   <= nsum;
                end
            end

            assign x_vld[k+1] = vld_r;
            assign x_sat[k+1] = sat_r;
            assign x_c[k+1]   = c_r;
            assign x_a[k+1]   = a_r;
            assign x_b[k+1]   = b_r;
            assign x_s[k+1]   = s_r;
        end else begin : g_last
            logic [WIDTH-1:0] res;
            addsub_flags_t    flg;

            // Overflow iff carry into the msb differs from carry out of it.
            always_comb begin
                flg.cout = c_k;
                flg.ovf  = c_k ^ cmsb_k;
                res      = nsum;
                if (x_sat[k] && flg.ovf) begin
                    res = x_a[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
                end
                flg.zero = ~|res;
            end

            // Result and flags only load with a real beat so bubbles leave them untouched.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_q   <= 1'b0;
                    sum_q   <= '0;
                    flags_q <= '0;
                end else if (en) begin
                    vld_q <= x_vld[k];
                    if (x_vld[k]) begin
                        sum_q   <= res;
                        flags_q <= flg;
                    end
                end
            end
        end
    end

endmodule
